// File: rtl/qam_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qam_pkg
// Description : Shared symbol width, symbol type and fixed symbol constants
//               for the QAM/QPSK symbol feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package qam_pkg;

    localparam int unsigned SYMBOL_W = 2;

    typedef logic [SYMBOL_W-1:0] symbol_t;

    // Symbol driven after reset and whenever the FIFO runs dry at a boundary
    localparam symbol_t IDLE_SYMBOL_DEFAULT = 2'b00;

    // Preamble alternates between these two, starting with A
    localparam symbol_t PREAMBLE_SYM_A = 2'b11;
    localparam symbol_t PREAMBLE_SYM_B = 2'b00;

endpackage
`default_nettype wire

// File: rtl/qam_symbol_feeder_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered storage, combinational head
//               read, occupancy level and synchronous active-high reset.
//               DEPTH must be a power of two >= 2.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import qam_pkg::*;
#(
    parameter int unsigned WIDTH = SYMBOL_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign full     = (count_q == C_DEPTH);
    assign empty    = (count_q == '0);
    assign level    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Next-state: pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        w_do_push = push && !full;
        w_do_pop  = pop && !empty;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (w_do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only read while the FIFO is non-empty
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/qam_symbol_feeder.sv
`default_nettype none
// ============================================================================
// Module      : qam_symbol_feeder
// Description : Packs a valid/ready serial bit stream into 2-bit symbols,
//               buffers them and presents each one for SYMBOL_PERIOD enabled
//               clocks, flagging underrun when the FIFO is empty at a symbol
//               boundary after the first real symbol.
//               Optional macro QAM_SYMBOL_FEEDER_PREAMBLE_EN: emit PREAMBLE_LEN
//               alternating 11/00 symbols after reset before normal output.
// Revision    : 1.0 - initial release
// ============================================================================
module qam_symbol_feeder
    import qam_pkg::*;
#(
    parameter int unsigned SYMBOL_PERIOD = 16,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter symbol_t     IDLE_SYMBOL   = IDLE_SYMBOL_DEFAULT,
    parameter int unsigned PREAMBLE_LEN  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        bit_in,
    input  logic                        bit_valid,
    output logic                        bit_ready,
    output symbol_t                     data_out,
    output logic                        sym_strobe,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned CNT_W = (SYMBOL_PERIOD > 1) ? $clog2(SYMBOL_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             half_q, half_d;
    logic             msb_q, msb_d;
    logic             started_q, started_d;
    symbol_t          data_q, data_d;
    logic             strobe_q, strobe_d;
    logic             underrun_q, underrun_d;

    logic             w_accept;
    logic             w_boundary;
    logic             w_push;
    logic             w_pop;
    symbol_t          w_push_data;
    symbol_t          w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_in_preamble;
    symbol_t          w_pre_symbol;

    assign bit_ready   = !rst && !w_full;
    assign w_accept    = bit_valid && bit_ready;
    assign w_boundary  = en && (cnt_q == CNT_LAST);
    assign w_push_data = {msb_q, bit_in};

    sync_fifo #(
        .WIDTH (SYMBOL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .level     (fifo_level)
    );

`ifdef QAM_SYMBOL_FEEDER_PREAMBLE_EN
    localparam int unsigned PRE_W = $clog2(PREAMBLE_LEN + 1);
    localparam logic [PRE_W-1:0] PRE_END = PRE_W'(PREAMBLE_LEN);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

    assign w_in_preamble = (pre_cnt_q != PRE_END);
    assign w_pre_symbol  = pre_cnt_q[0] ? PREAMBLE_SYM_B : PREAMBLE_SYM_A;

    // Count preamble boundaries; saturates once the preamble is complete
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (w_boundary && w_in_preamble) begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end
    end

    // Preamble boundary counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end
`else
    logic w_unused_preamble;

    assign w_in_preamble     = 1'b0;
    assign w_pre_symbol      = PREAMBLE_SYM_A;
    assign w_unused_preamble = (PREAMBLE_LEN == 0);
`endif

    // Period counter, bit pairing and symbol selection at each boundary
    always_comb begin
        cnt_d      = cnt_q;
        half_d     = half_q;
        msb_d      = msb_q;
        started_d  = started_q;
        data_d     = data_q;
        strobe_d   = w_boundary;
        underrun_d = 1'b0;
        w_push     = 1'b0;
        w_pop      = 1'b0;

        if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end

        // First bit of a pair is parked; second completes and pushes it
        if (w_accept) begin
            if (half_q) begin
                w_push = 1'b1;
                half_d = 1'b0;
            end else begin
                msb_d  = bit_in;
                half_d = 1'b1;
            end
        end

        // Emptiness is the pre-edge state, so a same-edge push never falls through
        if (w_boundary) begin
            if (w_in_preamble) begin
                data_d = w_pre_symbol;
            end else if (!w_empty) begin
                w_pop     = 1'b1;
                data_d    = w_head;
                started_d = 1'b1;
            end else begin
                data_d     = IDLE_SYMBOL;
                underrun_d = started_q;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            half_q     <= 1'b0;
            msb_q      <= 1'b0;
            started_q  <= 1'b0;
            data_q     <= IDLE_SYMBOL;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            msb_q      <= msb_d;
            started_q  <= started_d;
            data_q     <= data_d;
            strobe_q   <= strobe_d;
            underrun_q <= underrun_d;
        end
    end

    assign data_out   = data_q;
    assign sym_strobe = strobe_q;
    assign underrun   = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_qam_symbol_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_qam_symbol_feeder
// Description : Self-checking bench for qam_symbol_feeder. A queue-based
//               reference model tracks accepted bits, stored symbols and the
//               enabled-cycle count; outputs are compared every cycle, plus
//               directed scenario checks and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qam_symbol_feeder;
    import qam_pkg::*;

    localparam int P       = 4;
    localparam int DEPTH   = 4;
    localparam int PRE_LEN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_ready;
    logic [1:0] data_out;
    logic       sym_strobe;
    logic       underrun;
    logic [2:0] fifo_level;

    qam_symbol_feeder #(
        .SYMBOL_PERIOD (P),
        .FIFO_DEPTH    (DEPTH),
        .IDLE_SYMBOL   (2'b00),
        .PREAMBLE_LEN  (PRE_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .data_out   (data_out),
        .sym_strobe (sym_strobe),
        .underrun   (underrun),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_q[$];
    bit m_half = 1'b0;
    int m_msb = 0;
    int m_en_cycles = 0;
    bit m_started = 1'b0;
    int m_data = 0;
    bit m_strobe = 1'b0;
    bit m_under = 1'b0;
    int m_pre_seen = 0;

    always @(posedge clk) begin
        bit acc, bnd, was_empty, in_pre;
        if (rst) begin
            m_q.delete();
            m_half = 1'b0; m_en_cycles = 0; m_started = 1'b0;
            m_data = 0; m_strobe = 1'b0; m_under = 1'b0; m_pre_seen = 0;
        end else begin
            acc       = bit_valid && (m_q.size() < DEPTH);
            bnd       = en && ((m_en_cycles % P) == P - 1);
            was_empty = (m_q.size() == 0);
            in_pre    = 1'b0;
`ifdef QAM_SYMBOL_FEEDER_PREAMBLE_EN
            in_pre    = (m_pre_seen < PRE_LEN);
`endif
            m_strobe  = bnd;
            m_under   = 1'b0;
            if (bnd) begin
                if (in_pre) begin
                    m_data = (m_pre_seen % 2 == 0) ? 3 : 0;
                    m_pre_seen++;
                end else if (!was_empty) begin
                    m_data    = m_q.pop_front();
                    m_started = 1'b1;
                end else begin
                    m_data  = 0;
                    m_under = m_started;
                end
            end
            if (acc) begin
                if (m_half) begin
                    m_q.push_back(m_msb * 2 + int'(bit_in));
                    m_half = 1'b0;
                end else begin
                    m_msb  = int'(bit_in);
                    m_half = 1'b1;
                end
            end
            if (en) m_en_cycles++;
        end
    end

    // ---------------- per-cycle checker and bit source ----------------
    bit chk_en = 1'b0;
    bit last_ready = 1'b0;
    bit tx_bits[$];
    int n_acc = 0;
    int log_q[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("data_out",   int'(data_out),   m_data);
            check("sym_strobe", int'(sym_strobe), int'(m_strobe));
            check("underrun",   int'(underrun),   int'(m_under));
            check("fifo_level", int'(fifo_level), m_q.size());
            check("bit_ready",  int'(bit_ready),  int'(!rst && (m_q.size() < DEPTH)));
            if (sym_strobe) log_q.push_back(int'(underrun) * 4 + int'(data_out));
        end
        if (bit_valid && last_ready && tx_bits.size() > 0) begin
            void'(tx_bits.pop_front());
            n_acc++;
        end
        if (tx_bits.size() > 0) begin
            bit_valid = 1'b1;
            bit_in    = tx_bits[0];
        end else begin
            bit_valid = 1'b0;
            bit_in    = 1'($urandom);
        end
        last_ready = bit_ready;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n, input logic en_after);
        @(posedge clk); #1;
        rst = 1'b1;
        tx_bits.delete();
        repeat (n) @(posedge clk);
        @(negedge clk); #1;
        check("rst_data_out",   int'(data_out),   0);
        check("rst_sym_strobe", int'(sym_strobe), 0);
        check("rst_underrun",   int'(underrun),   0);
        check("rst_fifo_level", int'(fifo_level), 0);
        check("rst_bit_ready",  int'(bit_ready),  0);
        @(posedge clk); #1;
        rst = 1'b0;
        en  = en_after;
        log_q.delete();
        n_acc = 0;
    endtask

    initial begin
        int und, nz, rate;
        bit b[10];

        @(posedge clk); #1;
        chk_en = 1'b1;

`ifndef QAM_SYMBOL_FEEDER_PREAMBLE_EN
        // Back-to-back stream 1,0,0,1,1,1 -> 10, 01, 11, then IDLE with underruns
        do_reset(2, 1'b1);
        tx_bits = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        cycles(21);
        check("a_strobes", log_q.size(), 5);
        if (log_q.size() >= 5) begin
            check("a_sym0", log_q[0], 2);
            check("a_sym1", log_q[1], 1);
            check("a_sym2", log_q[2], 3);
            check("a_idle3", log_q[3], 4);
            check("a_idle4", log_q[4], 4);
        end

        // Stalled source: IDLE every period, no underrun before a real symbol
        do_reset(1, 1'b1);
        cycles(41);
        und = 0; nz = 0;
        foreach (log_q[i]) begin
            if (log_q[i] / 4 != 0) und++;
            if (log_q[i] % 4 != 0) nz++;
        end
        check("b_strobes", log_q.size(), 10);
        check("b_underruns", und, 0);
        check("b_nonidle", nz, 0);
`endif

        // Backpressure with en=0: 8 bits fill the FIFO, remaining two wait
        do_reset(1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            b[i] = 1'($urandom);
            tx_bits.push_back(b[i]);
        end
        cycles(14);
        check("c_level_full", int'(fifo_level), 4);
        check("c_ready_low", int'(bit_ready), 0);
        check("c_pending", tx_bits.size(), 2);
        check("c_accepted8", n_acc, 8);
        en = 1'b1;
        cycles(9);
`ifndef QAM_SYMBOL_FEEDER_PREAMBLE_EN
        check("c_pending_done", tx_bits.size(), 0);
        check("c_level_after", int'(fifo_level), 3);
        if (log_q.size() >= 2) begin
            check("c_sym0", log_q[0], int'(b[0]) * 2 + int'(b[1]));
            check("c_sym1", log_q[1], int'(b[2]) * 2 + int'(b[3]));
        end else begin
            check("c_strobes", log_q.size(), 2);
        end

        // Lone half-pair is never emitted until its partner arrives
        do_reset(1, 1'b1);
        tx_bits.push_back(1'b1);
        cycles(13);
        check("d_level", int'(fifo_level), 0);
        check("d_data_idle", int'(data_out), 0);
        check("d_strobes", log_q.size(), 3);
        tx_bits.push_back(1'b0);
        cycles(4);
        check("d_sym", int'(data_out), 2);
`endif

        // Mid-symbol reset with 3 symbols stored and a half-pair pending
        do_reset(1, 1'b0);
        for (int i = 0; i < 7; i++) tx_bits.push_back(1'($urandom));
        cycles(9);
        check("e_level3", int'(fifo_level), 3);
        en = 1'b1;
        cycles(2);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        log_q.delete();
        check("e_data_idle", int'(data_out), 0);
        check("e_level0", int'(fifo_level), 0);
        check("e_strobe0", int'(sym_strobe), 0);
        check("e_under0", int'(underrun), 0);
        cycles(3);
        @(negedge clk); #1;
        check("e_no_early_strobe", log_q.size(), 0);
        @(negedge clk); #1;
        check("e_restart_strobe", log_q.size(), 1);

`ifdef QAM_SYMBOL_FEEDER_PREAMBLE_EN
        // Preamble 11,00,11,00 then the pre-filled 01
        do_reset(1, 1'b0);
        tx_bits = '{1'b0, 1'b1};
        cycles(3);
        en = 1'b1;
        cycles(21);
        check("p_strobes", log_q.size(), 5);
        if (log_q.size() >= 5) begin
            check("p_sym0", log_q[0], 3);
            check("p_sym1", log_q[1], 0);
            check("p_sym2", log_q[2], 3);
            check("p_sym3", log_q[3], 0);
            check("p_sym4", log_q[4], 1);
        end
`endif

        // Randomized traffic at several source rates, with occasional resets
        for (int r = 0; r < 4; r++) begin
            do_reset(1 + $urandom_range(2), 1'b1);
            rate = 2 + r * 2;
            for (int c = 0; c < 600; c++) begin
                en = ($urandom_range(9) != 0);
                if (tx_bits.size() < 2 && $urandom_range(rate - 1) == 0)
                    tx_bits.push_back(1'($urandom));
                if ($urandom_range(299) == 0) begin
                    rst = 1'b1;
                    cycles(1);
                    rst = 1'b0;
                end else begin
                    cycles(1);
                end
            end
        end

        cycles(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
